// File: rtl/delay_line_var.sv
// Runtime-programmable, stallable delay line carrying a valid flag with each sample.
// The line advances only on enabled cycles; a delay load flushes it and restarts the fill.
module delay_line_var #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 4,
    localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  delay_load_i,
    input  logic [DLY_W-1:0]      delay_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic [DLY_W-1:0]      delay_o
);

    localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_DELAY);
    localparam logic [DLY_W-1:0] DEF_D = DLY_W'(DEFAULT_DELAY);

    logic [DLY_W-1:0]      delay_q;
    logic [DLY_W-1:0]      fill_q;
    logic [MAX_DELAY-1:0]  vld_q;
    logic [DATA_WIDTH-1:0] data_q [MAX_DELAY];
    logic                  sel_vld;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  busy;

    // Oversized requests clamp to the deepest line rather than wrapping.
    function automatic logic [DLY_W-1:0] sat_delay(input logic [DLY_W-1:0] d);
        return (d > MAX_D) ? MAX_D : d;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            delay_q <= DEF_D;
            fill_q  <= '0;
            vld_q   <= '0;
            for (int k = 0; k < MAX_DELAY; k++) begin
                data_q[k] <= '0;
            end
        end else if (delay_load_i) begin
            // Flush drops in-flight samples and the sample presented on this cycle.
            delay_q <= sat_delay(delay_i);
            fill_q  <= '0;
            vld_q   <= '0;
        end else if (en_i) begin
            vld_q[0]  <= valid_i;
            data_q[0] <= data_i;
            for (int k = 1; k < MAX_DELAY; k++) begin
                vld_q[k]  <= vld_q[k-1];
                data_q[k] <= data_q[k-1];
            end
            if (fill_q < delay_q) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < MAX_DELAY; k++) begin
            if (DLY_W'(k + 1) == delay_q) begin
                sel_vld  = vld_q[k];
                sel_data = data_q[k];
            end
        end
        busy = (fill_q < delay_q);
        if (delay_q == '0) begin
            valid_o = valid_i;
            data_o  = data_i;
        end else begin
            // Data is masked so stale contents never leak out while invalid.
            valid_o = sel_vld & ~busy;
            data_o  = valid_o ? sel_data : '0;
        end
    end

    assign busy_o  = busy;
    assign delay_o = delay_q;

endmodule

// File: tb/tb_delay_line_var.sv
// Bench for delay_line_var: fixed vector table for the reset/stream case, then directed
// corner sequences and a random phase checked against a queue-based scoreboard.
module tb_delay_line_var;

    logic       clk = 1'b0;
    logic       rst_i, en_i, delay_load_i, valid_i;
    logic [4:0] delay_i;
    logic [7:0] data_i;
    logic       valid_o, busy_o;
    logic [7:0] data_o;
    logic [4:0] delay_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } samp_t;

    samp_t mq[$];
    int    mdly = 4;

    delay_line_var #(.DATA_WIDTH(8), .MAX_DELAY(16), .DEFAULT_DELAY(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .delay_load_i(delay_load_i),
        .delay_i(delay_i), .valid_i(valid_i), .data_i(data_i),
        .valid_o(valid_o), .data_o(data_o), .busy_o(busy_o), .delay_o(delay_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the scoreboard at the edge, compare #1 after it.
    task automatic step(input logic en, input logic v, input logic [7:0] d,
                        input logic ld, input logic [4:0] dl, input logic r);
        int    exp_busy;
        samp_t front;
        rst_i = r; en_i = en; valid_i = v; data_i = d; delay_load_i = ld; delay_i = dl;
        @(posedge clk);
        if (r) begin
            mdly = 4;
            mq.delete();
        end else if (ld) begin
            mdly = (int'(dl) > 16) ? 16 : int'(dl);
            mq.delete();
        end else if (en) begin
            mq.push_back('{v: v, d: d});
            if (mq.size() > mdly) void'(mq.pop_front());
        end
        #1;
        exp_busy = (mq.size() < mdly) ? 1 : 0;
        chk("delay_o", int'(delay_o), mdly);
        chk("busy_o", int'(busy_o), exp_busy);
        if (mdly == 0) begin
            chk("bypass_valid", int'(valid_o), int'(valid_i));
            chk("bypass_data", int'(data_o), int'(data_i));
        end else if (exp_busy == 1) begin
            chk("fill_valid", int'(valid_o), 0);
            chk("fill_data", int'(data_o), 0);
        end else begin
            front = mq[0];
            chk("valid_o", int'(valid_o), int'(front.v));
            if (front.v) chk("data_o", int'(data_o), int'(front.d));
        end
    endtask

    typedef struct {
        logic       en, v, ld, r;
        logic [7:0] d;
        logic [4:0] dl;
        logic       ev, eb;
        logic [7:0] ed;
        logic [4:0] edl;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic       hold_v;
        logic [7:0] hold_d;
        int         busy_cnt;
        int         first_data;

        tbl[0] = '{en:0, v:0, ld:0, r:1, d:8'h00, dl:0, ev:0, eb:1, ed:8'h00, edl:4};
        tbl[1] = '{en:1, v:1, ld:0, r:0, d:8'h01, dl:0, ev:0, eb:1, ed:8'h00, edl:4};
        tbl[2] = '{en:1, v:1, ld:0, r:0, d:8'h02, dl:0, ev:0, eb:1, ed:8'h00, edl:4};
        tbl[3] = '{en:1, v:1, ld:0, r:0, d:8'h03, dl:0, ev:0, eb:1, ed:8'h00, edl:4};
        tbl[4] = '{en:1, v:1, ld:0, r:0, d:8'h04, dl:0, ev:1, eb:0, ed:8'h01, edl:4};
        tbl[5] = '{en:1, v:1, ld:0, r:0, d:8'h05, dl:0, ev:1, eb:0, ed:8'h02, edl:4};
        tbl[6] = '{en:1, v:1, ld:0, r:0, d:8'h06, dl:0, ev:1, eb:0, ed:8'h03, edl:4};

        rst_i = 1; en_i = 0; delay_load_i = 0; delay_i = 0; valid_i = 0; data_i = 0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].ld, tbl[i].dl, tbl[i].r);
            chk("tbl_valid", int'(valid_o), int'(tbl[i].ev));
            chk("tbl_data", int'(data_o), int'(tbl[i].ed));
            chk("tbl_busy", int'(busy_o), int'(tbl[i].eb));
            chk("tbl_delay", int'(delay_o), int'(tbl[i].edl));
        end

        // Load 9 with a live sample on the load cycle; that sample must never emerge.
        step(1, 1, 8'hAA, 1, 5'd9, 0);
        busy_cnt = int'(busy_o);
        first_data = -1;
        for (int i = 0; i < 14; i++) begin
            step(1, 1, 8'(8'h10 + i), 0, 0, 0);
            busy_cnt += int'(busy_o);
            if (valid_o && first_data < 0) first_data = int'(data_o);
        end
        chk("load9_busy_cycles", busy_cnt, 9);
        chk("load9_first_data", first_data, 8'h10);

        // Delay 3, valid on cycles 0-5 with en low on cycles 2-3.
        step(1, 0, 0, 1, 5'd3, 0);
        for (int c = 0; c < 12; c++) begin
            hold_v = valid_o;
            hold_d = data_o;
            if (c == 2 || c == 3) begin
                step(0, 1, 8'hEE, 0, 0, 0);
                chk("stall_hold_valid", int'(valid_o), int'(hold_v));
                chk("stall_hold_data", int'(data_o), int'(hold_d));
            end else begin
                step(1, (c < 6) ? 1'b1 : 1'b0, 8'(8'h30 + c), 0, 0, 0);
            end
        end

        // Saturating load, then full-depth stream.
        step(1, 1, 8'h55, 1, 5'd20, 0);
        chk("sat_delay", int'(delay_o), 16);
        for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h80 + i), 0, 0, 0);

        // Zero delay: combinational bypass regardless of en_i.
        step(1, 1, 8'h66, 1, 5'd0, 0);
        for (int i = 0; i < 6; i++) step(logic'(i % 2), logic'(i % 3 != 0), 8'(8'hC0 + i), 0, 0, 0);

        // Mid-stream load of 2 with 4 samples in flight.
        step(1, 0, 0, 1, 5'd4, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 8'(8'hD0 + i), 0, 0, 0);
        step(1, 1, 8'hDF, 1, 5'd2, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 8'(8'hE0 + i), 0, 0, 0);

        // Reset mid-stream, then reset colliding with a load.
        step(1, 1, 8'h77, 0, 0, 1);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_data", int'(data_o), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h90 + i), 0, 0, 0);
        step(1, 1, 8'h99, 1, 5'd7, 1);
        chk("rst_beats_load", int'(delay_o), 4);

        // Random traffic with occasional loads and resets.
        for (int i = 0; i < 500; i++) begin
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), logic'($urandom_range(0, 29) == 0),
                 5'($urandom_range(0, 20)), logic'($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
